// File: rtl/ins_fetch_mem.sv
// ins_fetch_mem
//   Writable program memory with a registered, handshaked fetch port and a
//   decoded instruction output. It sits between the PC/sequencer and the
//   control decoder.
//
//   Optional feature: define INS_PARITY_EN to store an even-parity bit with
//   every word and report a mismatch on the registered par_err output.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   load_en/addr/data       program write port; it wins over fetch
//   fetch_req/addr/ready    fetch request handshake from the sequencer
//   ins_valid/ins_ready     one-entry output buffer handshake to the decoder
//   outins                  buffered instruction word
//   opcode, r1, r2          combinational field slices of outins
//   halted, halt_clr        STOP (all-ones) consumed flag and its clear
//   fetch_cnt               accepted-fetch counter, wraps at 16 bits
//   par_err                 (INS_PARITY_EN only) parity mismatch on fetch
//
// Handshake semantics: a transfer on either side happens on the rising edge
// where valid/req and ready are both high. fetch_ready is combinational and
// never depends on fetch_req. ins_valid does not depend on ins_ready. Once
// ins_valid is high, outins holds stable until a consume happens.
module ins_fetch_mem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OPC_W  = 8,
  parameter int R1_W   = 6,
  parameter int R2_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] outins,
  output logic [OPC_W-1:0]  opcode,
  output logic [R1_W-1:0]   r1,
  output logic [R2_W-1:0]   r2,
  output logic              halted,
  input  logic              halt_clr,
  output logic [15:0]       fetch_cnt
`ifdef INS_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Program storage. It has no reset: contents survive rst_n.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ins_valid_q, ins_valid_d;
  logic [DATA_W-1:0] outins_q,    outins_d;
  logic              halted_q,    halted_d;
  logic [15:0]       fetch_cnt_q, fetch_cnt_d;

  logic accept;
  logic consume;
  logic stop_consume;

`ifdef INS_PARITY_EN
  logic mem_par_q [DEPTH];
  logic par_err_q, par_err_d;
`endif

  always_comb begin
    // Load has priority over fetch, a halt blocks fetch, and a full buffer
    // only accepts when it is being drained in the same cycle.
    fetch_ready  = !load_en && !halted_q && (!ins_valid_q || ins_ready);
    accept       = fetch_req && fetch_ready;
    consume      = ins_valid_q && ins_ready;
    stop_consume = consume && (outins_q == {DATA_W{1'b1}});

    ins_valid_d = ins_valid_q;
    outins_d    = outins_q;
    fetch_cnt_d = fetch_cnt_q;
    halted_d    = halted_q;

    if (accept) begin
      // Covers the consume+accept case: buffer replaced with no bubble.
      ins_valid_d = 1'b1;
      outins_d    = mem_q[fetch_addr];
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end else if (consume) begin
      // outins keeps its last value; only the valid flag drops.
      ins_valid_d = 1'b0;
    end

    // A STOP consume beats a simultaneous halt_clr.
    if (stop_consume) begin
      halted_d = 1'b1;
    end else if (halt_clr) begin
      halted_d = 1'b0;
    end
  end

`ifdef INS_PARITY_EN
  always_comb begin
    par_err_d = par_err_q;
    if (accept) begin
      par_err_d = (^mem_q[fetch_addr]) != mem_par_q[fetch_addr];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_valid_q <= 1'b0;
      outins_q    <= '0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      ins_valid_q <= ins_valid_d;
      outins_q    <= outins_d;
      halted_q    <= halted_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Storage write port. A fetch is refused in a load cycle, so a read of
  // the same address on the following cycle sees the new word.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

`ifdef INS_PARITY_EN
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_par_q[load_addr] <= ^load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign ins_valid = ins_valid_q;
  assign outins    = outins_q;
  assign halted    = halted_q;
  assign fetch_cnt = fetch_cnt_q;

  // Field slices may overlap.
  assign opcode = outins_q[DATA_W-1 -: OPC_W];
  assign r1     = outins_q[R1_W-1:0];
  assign r2     = outins_q[R2_W-1:0];

endmodule

// File: tb/tb_ins_fetch_mem.sv
// Testbench for ins_fetch_mem: directed vectors with literal expectations,
// plus a transaction-level model checked against the DUT on every cycle.
module tb_ins_fetch_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              load_en = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic              ins_valid;
  logic              ins_ready = 1'b0;
  logic [DATA_W-1:0] outins;
  logic [7:0]        opcode;
  logic [5:0]        r1;
  logic [7:0]        r2;
  logic              halted;
  logic              halt_clr = 1'b0;
  logic [15:0]       fetch_cnt;
`ifdef INS_PARITY_EN
  logic              par_err;
`endif

  ins_fetch_mem dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .outins      (outins),
    .opcode      (opcode),
    .r1          (r1),
    .r2          (r2),
    .halted      (halted),
    .halt_clr    (halt_clr),
    .fetch_cnt   (fetch_cnt)
`ifdef INS_PARITY_EN
    ,
    .par_err     (par_err)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Program image and the buffered-instruction state, advanced one clock
  // edge at a time from the rules of the block.
  logic [DATA_W-1:0] mem_m [256];
  logic              m_valid;
  logic [DATA_W-1:0] m_out;
  logic              m_halted;
  int                m_cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
  end

  function automatic logic exp_ready();
    if (load_en) return 1'b0;
    if (m_halted) return 1'b0;
    if (m_valid && !ins_ready) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  = 1'b0;
      m_out    = '0;
      m_halted = 1'b0;
      m_cnt    = 0;
    end else begin
      logic took, drained, was_stop;
      took     = fetch_req && exp_ready();
      drained  = m_valid && ins_ready;
      was_stop = drained && (m_out == 16'hFFFF);
      if (took) begin
        m_out   = mem_m[fetch_addr];
        m_valid = 1'b1;
        m_cnt   = (m_cnt + 1) % 65536;
      end else if (drained) begin
        m_valid = 1'b0;
      end
      if (was_stop) m_halted = 1'b1;
      else if (halt_clr) m_halted = 1'b0;
      if (load_en) mem_m[load_addr] = load_data;
    end
  end

  // Per-cycle compare, 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && !done) begin
      check("m_fetch_ready", 32'(fetch_ready), 32'(exp_ready()));
      check("m_ins_valid",   32'(ins_valid),   32'(m_valid));
      check("m_outins",      32'(outins),      32'(m_out));
      check("m_opcode",      32'(opcode),      32'(m_out[15:8]));
      check("m_r1",          32'(r1),          32'(m_out[5:0]));
      check("m_r2",          32'(r2),          32'(m_out[7:0]));
      check("m_halted",      32'(halted),      32'(m_halted));
      check("m_fetch_cnt",   32'(fetch_cnt),   32'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    load_en = 1'b0; fetch_req = 1'b0; halt_clr = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a);
    fetch_req = 1'b1; fetch_addr = a;
  endtask

  // Watchdog: the directed sequence has no open-ended waits, but never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] prog [11];

  // ---------------- directed sequence ----------------
  initial begin
    prog[0] = 16'h0000; prog[1] = 16'h0100; prog[2]  = 16'h0200;
    prog[3] = 16'h0300; prog[4] = 16'h0400; prog[5]  = 16'h0500;
    prog[6] = 16'h0600; prog[7] = 16'h0701; prog[8]  = 16'h0803;
    prog[9] = 16'h0902; prog[10] = 16'hFFFF;

    tick(); tick();
    check("rst_ins_valid", 32'(ins_valid), 0);
    check("rst_outins",    32'(outins),    0);
    check("rst_halted",    32'(halted),    0);
    check("rst_fetch_cnt", 32'(fetch_cnt), 0);
    rst_n = 1'b1;

    // Program load.
    for (int i = 0; i < 11; i++) begin
      load_en = 1'b1; load_addr = 8'(i); load_data = prog[i];
      tick();
    end
    idle();

    // Single fetch of address 7.
    ins_ready = 1'b1;
    fetch(8'h07);
    tick();
    idle();
    check("f7_valid",  32'(ins_valid), 1);
    check("f7_outins", 32'(outins),    32'h0701);
    check("f7_opcode", 32'(opcode),    32'h07);
    check("f7_r1",     32'(r1),        32'h01);
    check("f7_r2",     32'(r2),        32'h01);
    check("f7_cnt",    32'(fetch_cnt), 1);
    tick();
    check("f7_drained", 32'(ins_valid), 0);

    // Back-to-back 5,6,8 with no bubble.
    fetch(8'h05); tick();
    check("b2b_5", 32'(outins), 32'h0500);
    fetch(8'h06); tick();
    check("b2b_6", 32'(outins), 32'h0600);
    check("b2b_6_valid", 32'(ins_valid), 1);
    fetch(8'h08); tick();
    idle();
    check("b2b_8", 32'(outins), 32'h0803);
    check("b2b_cnt", 32'(fetch_cnt), 4);
    tick();

    // Stall on address 9.
    ins_ready = 1'b0;
    fetch(8'h09); tick();
    fetch(8'h05);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready",  32'(fetch_ready), 0);
      check("stall_outins", 32'(outins),      32'h0902);
      tick();
    end
    idle();
    ins_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(fetch_ready), 1);
    tick();
    check("unstall_valid", 32'(ins_valid), 0);
    check("unstall_cnt",   32'(fetch_cnt), 5);

    // STOP word.
    fetch(8'h0A); tick();
    idle();
    check("stop_outins", 32'(outins), 32'hFFFF);
    tick();
    check("stop_halted", 32'(halted), 1);
    fetch(8'h07); tick(); tick();
    #1;
    check("halt_ready", 32'(fetch_ready), 0);
    check("halt_cnt",   32'(fetch_cnt),   6);
    check("halt_valid", 32'(ins_valid),   0);
    idle();
    halt_clr = 1'b1; tick();
    halt_clr = 1'b0;
    check("halt_cleared", 32'(halted), 0);

    // STOP consume and halt_clr in the same cycle: STOP wins.
    ins_ready = 1'b0;
    fetch(8'h0A); tick();
    idle();
    ins_ready = 1'b1; halt_clr = 1'b1; tick();
    check("stop_beats_clr", 32'(halted), 1);
    tick();
    halt_clr = 1'b0;
    check("clr_after", 32'(halted), 0);

    // Load/fetch collision on 0x20.
    load_en = 1'b1; load_addr = 8'h20; load_data = 16'h1234;
    fetch(8'h20);
    #1;
    check("coll_ready", 32'(fetch_ready), 0);
    tick();
    load_en = 1'b0;
    check("coll_valid", 32'(ins_valid), 0);
    check("coll_cnt",   32'(fetch_cnt), 7);
    tick();
    idle();
    check("coll_new_data", 32'(outins),    32'h1234);
    check("coll_cnt2",     32'(fetch_cnt), 8);
    tick();

    // Reset while the buffer is full.
    ins_ready = 1'b0;
    fetch(8'h07); tick();
    idle();
    check("pre_rst_valid", 32'(ins_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",  32'(ins_valid), 0);
    check("mid_rst_outins", 32'(outins),    0);
    check("mid_rst_cnt",    32'(fetch_cnt), 0);
    tick();
    rst_n = 1'b1;
    ins_ready = 1'b1;
    fetch(8'h07); tick();
    idle();
    check("post_rst_mem", 32'(outins),    32'h0701);
    check("post_rst_cnt", 32'(fetch_cnt), 1);
    tick(); tick();

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
